// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Hardwired control unit that sits directly upstream of the datapath. It steps
// through fetch (T0-T2) and execute (T3-T6) for register-format ALU, NEG/NOT,
// MUL/DIV and HALT instructions. It generates every datapath strobe from the
// current state and the IR value that the datapath returns.
//
// Ports
//   i_clock            rising-edge clock
//   i_clear            asynchronous active-high reset (state -> RESET, counter -> 0)
//   i_ir[31:0]         IR contents: op=[31:27] Ra=[26:23] Rb=[22:19] Rc=[18:15]
//   i_stop             halt at the next instruction boundary instead of fetching
//   o_run              1 while sequencing (T0..T6)
//   o_rin/o_rout       one-hot register load / bus-drive selects (bit n -> Rn)
//   o_pcout..o_loin    single-bit datapath strobes
//   o_op[4:0]          ALU operation code
// Parameters
//   MEM_WAIT           extra cycles T1 is held; T1 lasts MEM_WAIT+1 cycles
//   NREG               number of general registers
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter int MEM_WAIT = 0,
  parameter int NREG     = 16
) (
  input  logic            i_clock,
  input  logic            i_clear,
  input  logic [31:0]     i_ir,
  input  logic            i_stop,
  output logic            o_run,
  output logic [NREG-1:0] o_rin,
  output logic [NREG-1:0] o_rout,
  output logic            o_pcout,
  output logic            o_pcin,
  output logic            o_incpc,
  output logic            o_marin,
  output logic            o_mdrin,
  output logic            o_mdrout,
  output logic            o_read,
  output logic            o_irin,
  output logic            o_yin,
  output logic            o_zhighin,
  output logic            o_zlowin,
  output logic            o_zhighout,
  output logic            o_zlowout,
  output logic            o_hiin,
  output logic            o_loin,
  output logic [4:0]      o_op
);

  localparam int            CW        = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT);

  typedef enum logic [3:0] {
    S_RESET = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4    = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_HALT = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    C_NOP = 3'd0, C_ALU3 = 3'd1, C_UNARY = 3'd2, C_MULDIV = 3'd3, C_HALT = 3'd4
  } iclass_t;

  state_t        r_state;
  state_t        w_state_nxt;
  state_t        w_boundary;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  iclass_t       w_class;
  logic [4:0]    w_alu_op;
  logic [4:0]    w_opc;
  logic [3:0]    w_ra;
  logic [3:0]    w_rb;
  logic [3:0]    w_rc;
  logic          w_unused_ir;

  assign w_opc       = i_ir[31:27];
  assign w_ra        = i_ir[26:23];
  assign w_rb        = i_ir[22:19];
  assign w_rc        = i_ir[18:15];
  assign w_unused_ir = ^i_ir[14:0];

  // One-hot select; an index with no matching register yields all zeros.
  function automatic logic [NREG-1:0] f_onehot(input logic [3:0] idx);
    logic [NREG-1:0] v;
    for (int n = 0; n < NREG; n++) begin
      v[n] = (32'(idx) == n);
    end
    return v;
  endfunction

  // Opcode class and ALU code decode.
  always_comb begin
    w_class  = C_NOP;
    w_alu_op = 5'd0;
    case (w_opc)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: begin
        w_class  = C_ALU3;
        w_alu_op = w_opc;
      end
      5'd17: begin
        w_class  = C_UNARY;
        w_alu_op = 5'd1;
      end
      5'd18: begin
        w_class  = C_UNARY;
        w_alu_op = 5'd2;
      end
      5'd15, 5'd16: begin
        w_class  = C_MULDIV;
        w_alu_op = w_opc;
      end
      5'd27: begin
        w_class  = C_HALT;
        w_alu_op = 5'd0;
      end
      default: begin
        w_class  = C_NOP;
        w_alu_op = 5'd0;
      end
    endcase
  end

  // Next state, wait counter and all strobes from state + IR.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_boundary  = i_stop ? S_HALT : S_T0;
    o_run       = 1'b0;
    o_rin       = '0;
    o_rout      = '0;
    o_pcout     = 1'b0;
    o_pcin      = 1'b0;
    o_incpc     = 1'b0;
    o_marin     = 1'b0;
    o_mdrin     = 1'b0;
    o_mdrout    = 1'b0;
    o_read      = 1'b0;
    o_irin      = 1'b0;
    o_yin       = 1'b0;
    o_zhighin   = 1'b0;
    o_zlowin    = 1'b0;
    o_zhighout  = 1'b0;
    o_zlowout   = 1'b0;
    o_hiin      = 1'b0;
    o_loin      = 1'b0;
    o_op        = 5'd0;
    case (r_state)
      S_RESET: begin
        w_state_nxt = w_boundary;
      end
      S_T0: begin
        o_run       = 1'b1;
        o_pcout     = 1'b1;
        o_marin     = 1'b1;
        o_incpc     = 1'b1;
        o_zlowin    = 1'b1;
        w_state_nxt = S_T1;
      end
      S_T1: begin
        o_run   = 1'b1;
        o_read  = 1'b1;
        o_mdrin = 1'b1;
        // PC reload from Z happens only once, on the first T1 cycle.
        if (r_cnt == '0) begin
          o_zlowout = 1'b1;
          o_pcin    = 1'b1;
        end else begin
          o_zlowout = 1'b0;
          o_pcin    = 1'b0;
        end
        if (r_cnt == WAIT_LAST) begin
          w_state_nxt = S_T2;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = S_T1;
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      S_T2: begin
        o_run       = 1'b1;
        o_mdrout    = 1'b1;
        o_irin      = 1'b1;
        w_state_nxt = S_T3;
      end
      S_T3: begin
        o_run = 1'b1;
        case (w_class)
          C_ALU3: begin
            o_rout      = f_onehot(w_rb);
            o_yin       = 1'b1;
            w_state_nxt = S_T4;
          end
          C_UNARY: begin
            o_rout      = f_onehot(w_rb);
            o_op        = w_alu_op;
            o_zlowin    = 1'b1;
            w_state_nxt = S_T4;
          end
          C_MULDIV: begin
            o_rout      = f_onehot(w_ra);
            o_yin       = 1'b1;
            w_state_nxt = S_T4;
          end
          C_HALT:  w_state_nxt = S_HALT;
          default: w_state_nxt = w_boundary;
        endcase
      end
      S_T4: begin
        o_run = 1'b1;
        if (w_class == C_UNARY) begin
          o_zlowout   = 1'b1;
          o_rin       = f_onehot(w_ra);
          w_state_nxt = w_boundary;
        end else begin
          // 3-reg ALU second operand is Rc; MUL/DIV second operand is Rb.
          o_rout      = f_onehot((w_class == C_MULDIV) ? w_rb : w_rc);
          o_op        = w_alu_op;
          o_zhighin   = 1'b1;
          o_zlowin    = 1'b1;
          w_state_nxt = S_T5;
        end
      end
      S_T5: begin
        o_run     = 1'b1;
        o_zlowout = 1'b1;
        if (w_class == C_MULDIV) begin
          o_loin      = 1'b1;
          w_state_nxt = S_T6;
        end else begin
          o_rin       = f_onehot(w_ra);
          w_state_nxt = w_boundary;
        end
      end
      S_T6: begin
        o_run       = 1'b1;
        o_zhighout  = 1'b1;
        o_hiin      = 1'b1;
        w_state_nxt = w_boundary;
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_RESET;
      end
    endcase
  end

  // State register and T1 wait counter.
  always_ff @(posedge i_clock or posedge i_clear) begin
    if (i_clear) begin
      r_state <= S_RESET;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer. Two instances share stimulus: u0 (MEM_WAIT=0,
// NREG=16) and u2 (MEM_WAIT=2, NREG=8, so register indices 8..15 select nothing).
// A behavioural model expands each instruction into its list of per-cycle strobe
// words and is compared against both instances on every falling edge; directed
// literal checks pin specific cycles by hand.
module tb_control_sequencer;

  typedef struct packed {
    logic        run;
    logic [15:0] rin;
    logic [15:0] rout;
    logic        pcout, pcin, incpc, marin, mdrin, mdrout, rd, irin, yin;
    logic        zhighin, zlowin, zhighout, zlowout, hiin, loin;
    logic [4:0]  op;
  } ctl_t;

  logic        clk = 1'b0;
  logic        clear;
  logic        stop;
  logic [31:0] ir;
  int          n_checks = 0;
  int          n_pass   = 0;

  wire [1:0]  run, pcout, pcin, incpc, marin, mdrin, mdrout, rd, irin, yin;
  wire [1:0]  zhighin, zlowin, zhighout, zlowout, hiin, loin;
  wire [15:0] rin0, rout0;
  wire [7:0]  rin2, rout2;
  wire [4:0]  op0, op2;

  always #5 clk = ~clk;

  control_sequencer #(.MEM_WAIT(0), .NREG(16)) u0 (
    .i_clock(clk), .i_clear(clear), .i_ir(ir), .i_stop(stop),
    .o_run(run[0]), .o_rin(rin0), .o_rout(rout0),
    .o_pcout(pcout[0]), .o_pcin(pcin[0]), .o_incpc(incpc[0]), .o_marin(marin[0]),
    .o_mdrin(mdrin[0]), .o_mdrout(mdrout[0]), .o_read(rd[0]), .o_irin(irin[0]),
    .o_yin(yin[0]), .o_zhighin(zhighin[0]), .o_zlowin(zlowin[0]),
    .o_zhighout(zhighout[0]), .o_zlowout(zlowout[0]), .o_hiin(hiin[0]),
    .o_loin(loin[0]), .o_op(op0)
  );

  control_sequencer #(.MEM_WAIT(2), .NREG(8)) u2 (
    .i_clock(clk), .i_clear(clear), .i_ir(ir), .i_stop(stop),
    .o_run(run[1]), .o_rin(rin2), .o_rout(rout2),
    .o_pcout(pcout[1]), .o_pcin(pcin[1]), .o_incpc(incpc[1]), .o_marin(marin[1]),
    .o_mdrin(mdrin[1]), .o_mdrout(mdrout[1]), .o_read(rd[1]), .o_irin(irin[1]),
    .o_yin(yin[1]), .o_zhighin(zhighin[1]), .o_zlowin(zlowin[1]),
    .o_zhighout(zhighout[1]), .o_zlowout(zlowout[1]), .o_hiin(hiin[1]),
    .o_loin(loin[1]), .o_op(op2)
  );

  // ---------------- behavioural model ----------------
  // mode: 0 = reset cycle, 1 = running an expanded instruction, 2 = halted
  int   mode [2];
  ctl_t seq  [2][0:15];
  int   len  [2];
  int   pos  [2];
  bit   halt_after [2];

  function automatic ctl_t c0();
    ctl_t c = '0;
    c.run = 1'b1;
    return c;
  endfunction

  function automatic logic [15:0] oh(int idx, int nreg);
    logic [15:0] v = 16'd0;
    if (idx < nreg) v[idx] = 1'b1;
    return v;
  endfunction

  task automatic push(int i, ctl_t c);
    seq[i][len[i]] = c;
    len[i] = len[i] + 1;
  endtask

  // Fetch cycles, then a run=0 marker entry where the execute part is decoded.
  task automatic load_fetch(int i);
    ctl_t c;
    len[i] = 0; pos[i] = 0; halt_after[i] = 1'b0;
    c = c0(); c.pcout = 1'b1; c.marin = 1'b1; c.incpc = 1'b1; c.zlowin = 1'b1; push(i, c);
    for (int k = 0; k <= ((i == 0) ? 0 : 2); k++) begin
      c = c0(); c.rd = 1'b1; c.mdrin = 1'b1;
      if (k == 0) begin c.pcin = 1'b1; c.zlowout = 1'b1; end
      push(i, c);
    end
    c = c0(); c.mdrout = 1'b1; c.irin = 1'b1; push(i, c);
    push(i, ctl_t'(0));
  endtask

  task automatic load_exec(int i);
    logic [4:0] op;
    int ra, rb, rc, nr;
    ctl_t c;
    op = ir[31:27]; ra = int'(ir[26:23]); rb = int'(ir[22:19]); rc = int'(ir[18:15]);
    nr = (i == 0) ? 16 : 8;
    if (op >= 5'd3 && op <= 5'd10) begin
      c = c0(); c.rout = oh(rb, nr); c.yin = 1'b1; push(i, c);
      c = c0(); c.rout = oh(rc, nr); c.op = op; c.zhighin = 1'b1; c.zlowin = 1'b1; push(i, c);
      c = c0(); c.zlowout = 1'b1; c.rin = oh(ra, nr); push(i, c);
    end else if (op == 5'd17 || op == 5'd18) begin
      c = c0(); c.rout = oh(rb, nr); c.op = (op == 5'd17) ? 5'd1 : 5'd2; c.zlowin = 1'b1; push(i, c);
      c = c0(); c.zlowout = 1'b1; c.rin = oh(ra, nr); push(i, c);
    end else if (op == 5'd15 || op == 5'd16) begin
      c = c0(); c.rout = oh(ra, nr); c.yin = 1'b1; push(i, c);
      c = c0(); c.rout = oh(rb, nr); c.op = op; c.zhighin = 1'b1; c.zlowin = 1'b1; push(i, c);
      c = c0(); c.zlowout = 1'b1; c.loin = 1'b1; push(i, c);
      c = c0(); c.zhighout = 1'b1; c.hiin = 1'b1; push(i, c);
    end else begin
      push(i, c0());
      if (op == 5'd27) halt_after[i] = 1'b1;
    end
  endtask

  task automatic decide(int i);
    if (halt_after[i] || stop) mode[i] = 2;
    else begin mode[i] = 1; load_fetch(i); end
  endtask

  function automatic ctl_t actual(int i);
    ctl_t a = '0;
    a.run = run[i];
    a.rin = (i == 0) ? rin0 : {8'd0, rin2};
    a.rout = (i == 0) ? rout0 : {8'd0, rout2};
    a.pcout = pcout[i]; a.pcin = pcin[i]; a.incpc = incpc[i]; a.marin = marin[i];
    a.mdrin = mdrin[i]; a.mdrout = mdrout[i]; a.rd = rd[i]; a.irin = irin[i];
    a.yin = yin[i]; a.zhighin = zhighin[i]; a.zlowin = zlowin[i];
    a.zhighout = zhighout[i]; a.zlowout = zlowout[i]; a.hiin = hiin[i]; a.loin = loin[i];
    a.op = (i == 0) ? op0 : op2;
    return a;
  endfunction

  // Compare process: advance the model one cycle and check both instances.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      ctl_t e;
      ctl_t a;
      if (clear) begin
        mode[i] = 0; halt_after[i] = 1'b0; e = '0;
      end else if (mode[i] == 0) begin
        e = '0; decide(i);
      end else if (mode[i] == 2) begin
        e = '0;
      end else begin
        if (!seq[i][pos[i]].run) begin load_exec(i); pos[i] = pos[i] + 1; end
        e = seq[i][pos[i]];
        pos[i] = pos[i] + 1;
        if (pos[i] == len[i]) decide(i);
      end
      a = actual(i);
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL model u%0d t=%0t actual=%h required=%h", (i == 0) ? 0 : 2, $time, a, e);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic lit(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  // Advance n rising edges and settle 3 time units after the last one.
  task automatic at(int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  // One-cycle Clear pulse; returns inside the RESET cycle.
  task automatic restart(logic [31:0] new_ir, logic s);
    clear = 1'b1; ir = new_ir; stop = s;
    at(1);
    clear = 1'b0;
  endtask

  function automatic logic [31:0] mk(logic [4:0] op, logic [3:0] a, logic [3:0] b, logic [3:0] c);
    return {op, a, b, c, 15'd0};
  endfunction

  localparam logic [31:0] I_NOT  = 32'h90080000;
  localparam logic [31:0] I_ADD  = 32'h18918000;
  localparam logic [31:0] I_MUL  = 32'h78900000;
  localparam logic [31:0] I_HALT = 32'hD8000000;
  localparam logic [31:0] I_NOP  = 32'hD0000000;

  logic [31:0] table_ir [12];

  initial begin
    clear = 1'b1; stop = 1'b0; ir = I_NOT;
    // reset state and NOT R0,R1 with MEM_WAIT=0
    at(2);
    lit("reset_run", {31'd0, run[0]}, 32'd0);
    lit("reset_op", {27'd0, op0}, 32'd0);
    clear = 1'b0;
    at(4);
    lit("not_t3_rout", {16'd0, rout0}, 32'h0002);
    lit("not_t3_op", {27'd0, op0}, 32'd2);
    lit("not_t3_zlowin", {31'd0, zlowin[0]}, 32'd1);
    at(1);
    lit("not_t4_rin", {16'd0, rin0}, 32'h0001);
    lit("not_t4_zlowout", {31'd0, zlowout[0]}, 32'd1);
    at(1);
    lit("not_next_t0", {31'd0, pcout[0]}, 32'd1);

    // ADD R1,R2,R3 on the MEM_WAIT=2 instance
    restart(I_ADD, 1'b0);
    at(2);
    lit("add_t1a_pcin", {31'd0, pcin[1]}, 32'd1);
    at(1);
    lit("add_t1b_pcin", {31'd0, pcin[1]}, 32'd0);
    lit("add_t1b_read", {31'd0, rd[1]}, 32'd1);
    at(3);
    lit("add_t3_rout", {24'd0, rout2}, 32'h04);
    lit("add_t3_yin", {31'd0, yin[1]}, 32'd1);
    at(1);
    lit("add_t4_rout", {24'd0, rout2}, 32'h08);
    lit("add_t4_op", {27'd0, op2}, 32'd3);
    at(1);
    lit("add_t5_rin", {24'd0, rin2}, 32'h02);
    at(1);
    lit("add_next_t0", {31'd0, pcout[1]}, 32'd1);

    // Clear mid-T4
    restart(I_ADD, 1'b0);
    at(5);
    lit("clr_pre_zhighin", {31'd0, zhighin[0]}, 32'd1);
    clear = 1'b1;
    #1;
    lit("clr_run", {31'd0, run[0]}, 32'd0);
    lit("clr_zlowin", {31'd0, zlowin[0]}, 32'd0);
    lit("clr_rout", {16'd0, rout0}, 32'd0);
    lit("clr_op", {27'd0, op0}, 32'd0);
    at(1);
    clear = 1'b0;
    lit("clr_reset_run", {31'd0, run[0]}, 32'd0);
    at(1);
    lit("clr_then_t0", {31'd0, pcout[0]}, 32'd1);
    at(1);
    lit("clr_then_t1", {31'd0, rd[0]}, 32'd1);

    // MUL R1,R2
    restart(I_MUL, 1'b0);
    at(4);
    lit("mul_t3_rout", {16'd0, rout0}, 32'h0002);
    at(1);
    lit("mul_t4_rout", {16'd0, rout0}, 32'h0004);
    lit("mul_t4_op", {27'd0, op0}, 32'd15);
    at(1);
    lit("mul_t5_lo", {30'd0, zlowout[0], loin[0]}, 32'd3);
    at(1);
    lit("mul_t6_hi", {30'd0, zhighout[0], hiin[0]}, 32'd3);
    at(1);
    lit("mul_next_t0", {31'd0, pcout[0]}, 32'd1);

    // Stop raised during T4 of ADD
    restart(I_ADD, 1'b0);
    at(5);
    stop = 1'b1;
    at(1);
    lit("stop_t5_rin", {16'd0, rin0}, 32'h0002);
    at(1);
    lit("stop_halt_run", {31'd0, run[0]}, 32'd0);
    at(1);
    stop = 1'b0;
    at(5);
    lit("stop_sticky_run", {31'd0, run[0]}, 32'd0);

    // HALT and NOP
    restart(I_HALT, 1'b0);
    at(4);
    lit("halt_t3_run", {31'd0, run[0]}, 32'd1);
    at(1);
    lit("halt_run", {31'd0, run[0]}, 32'd0);
    at(3);
    lit("halt_sticky", {31'd0, run[0]}, 32'd0);
    restart(I_NOP, 1'b0);
    at(4);
    lit("nop_t3_pcout", {31'd0, pcout[0]}, 32'd0);
    at(1);
    lit("nop_next_t0", {31'd0, pcout[0]}, 32'd1);

    // Stop held through reset release diverts RESET straight to HALT
    restart(I_NOT, 1'b1);
    at(1);
    lit("stop_reset_run", {31'd0, run[0]}, 32'd0);
    at(2);
    stop = 1'b0;
    at(2);

    // Opcode/register table checked by the model alone
    table_ir[0]  = mk(5'd3,  4'd5,  4'd5,  4'd5);
    table_ir[1]  = mk(5'd10, 4'd15, 4'd9,  4'd0);
    table_ir[2]  = mk(5'd17, 4'd2,  4'd7,  4'd0);
    table_ir[3]  = mk(5'd16, 4'd12, 4'd5,  4'd0);
    table_ir[4]  = mk(5'd0,  4'd1,  4'd2,  4'd3);
    table_ir[5]  = mk(5'd31, 4'd1,  4'd2,  4'd3);
    table_ir[6]  = mk(5'd11, 4'd1,  4'd2,  4'd3);
    table_ir[7]  = mk(5'd2,  4'd1,  4'd2,  4'd3);
    table_ir[8]  = mk(5'd14, 4'd1,  4'd2,  4'd3);
    table_ir[9]  = mk(5'd18, 4'd9,  4'd9,  4'd0);
    table_ir[10] = mk(5'd15, 4'd8,  4'd8,  4'd0);
    table_ir[11] = mk(5'd7,  4'd3,  4'd11, 4'd14);
    for (int k = 0; k < 12; k++) begin
      restart(table_ir[k], 1'b0);
      at(30);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
